// File: rtl/binary_blob_tracker.sv
// Per-frame blob statistics on a binary pixel mask: set-pixel count, bounding box and
// centroid (two restoring dividers), handed to the consumer through a VALID/ACK pair.
module binary_blob_tracker #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int MIN_PIXELS = 16,
    parameter int CW         = 11,
    parameter int SUM_W      = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          FRAME_START,
    input  logic          PIX_VALID,
    input  logic          BINARY_FLAG,
    output logic          RESULT_VALID,
    input  logic          RESULT_ACK,
    output logic          FOUND,
    output logic [19:0]   PIX_COUNT,
    output logic [CW-1:0] CENT_X,
    output logic [CW-1:0] CENT_Y,
    output logic [CW-1:0] XMIN,
    output logic [CW-1:0] XMAX,
    output logic [CW-1:0] YMIN,
    output logic [CW-1:0] YMAX,
    output logic          BUSY,
    output logic          OVERRUN
);

    localparam int PCW = 20;
    localparam int SCW = $clog2(SUM_W);
    localparam logic [PCW-1:0] COUNT_MAX = {PCW{1'b1}};
    localparam logic [PCW-1:0] MIN_CNT   = PCW'(MIN_PIXELS);
    localparam logic [CW-1:0]  X_LAST    = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0]  Y_LAST    = CW'(V_ACTIVE - 1);
    localparam logic [SCW-1:0] LAST_STEP = SCW'(SUM_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DIVIDE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      x_q, x_d, y_q, y_d;
    logic [SUM_W-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [PCW-1:0]     count_q, count_d;
    logic [CW-1:0]      xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [SUM_W:0]     rem_x_q, rem_x_d, rem_y_q, rem_y_d;
    logic [SUM_W-1:0]   quo_x_q, quo_x_d, quo_y_q, quo_y_d;
    logic [PCW-1:0]     divisor_q, divisor_d;
    logic [SCW-1:0]     step_q, step_d;
    logic               valid_q, valid_d, found_q, found_d, busy_q, busy_d, overrun_q, overrun_d;
    logic [PCW-1:0]     res_count_q, res_count_d;
    logic [CW-1:0]      cent_x_q, cent_x_d, cent_y_q, cent_y_d;
    logic [CW-1:0]      res_xmin_q, res_xmin_d, res_xmax_q, res_xmax_d;
    logic [CW-1:0]      res_ymin_q, res_ymin_d, res_ymax_q, res_ymax_d;
    logic               start_s, publish_s, found_pub_s;
    logic [2*SUM_W:0]   step_x_s, step_y_s;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [2*SUM_W:0] div_step(input logic [SUM_W:0]   rem,
                                                   input logic [SUM_W-1:0] quo,
                                                   input logic [PCW-1:0]   dvs);
        logic [SUM_W:0] shifted;
        logic [SUM_W:0] dv;
        shifted = {rem[SUM_W-1:0], quo[SUM_W-1]};
        dv      = (SUM_W+1)'(dvs);
        if (shifted >= dv) begin
            return {shifted - dv, quo[SUM_W-2:0], 1'b1};
        end else begin
            return {shifted, quo[SUM_W-2:0], 1'b0};
        end
    endfunction

    // Divider step values for both axes.
    always_comb begin
        step_x_s = div_step(rem_x_q, quo_x_q, divisor_q);
        step_y_s = div_step(rem_y_q, quo_y_q, divisor_q);
    end

    // Next-state, accumulation, divider and result-publishing logic.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        sum_x_d     = sum_x_q;
        sum_y_d     = sum_y_q;
        count_d     = count_q;
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymin_d      = ymin_q;
        ymax_d      = ymax_q;
        rem_x_d     = rem_x_q;
        quo_x_d     = quo_x_q;
        rem_y_d     = rem_y_q;
        quo_y_d     = quo_y_q;
        divisor_d   = divisor_q;
        step_d      = step_q;
        valid_d     = valid_q;
        found_d     = found_q;
        res_count_d = res_count_q;
        cent_x_d    = cent_x_q;
        cent_y_d    = cent_y_q;
        res_xmin_d  = res_xmin_q;
        res_xmax_d  = res_xmax_q;
        res_ymin_d  = res_ymin_q;
        res_ymax_d  = res_ymax_q;
        overrun_d   = 1'b0;
        start_s     = 1'b0;
        publish_s   = 1'b0;
        found_pub_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (FRAME_START) begin
                    start_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (FRAME_START) begin
                    start_s   = 1'b1;
                    overrun_d = 1'b1;
                end else if (PIX_VALID) begin
                    if (BINARY_FLAG) begin
                        sum_x_d = sum_x_q + SUM_W'(x_q);
                        sum_y_d = sum_y_q + SUM_W'(y_q);
                        count_d = (count_q != COUNT_MAX) ? count_q + PCW'(1) : count_q;
                        xmin_d  = (x_q < xmin_q) ? x_q : xmin_q;
                        xmax_d  = (x_q > xmax_q) ? x_q : xmax_q;
                        ymin_d  = (y_q < ymin_q) ? y_q : ymin_q;
                        ymax_d  = (y_q > ymax_q) ? y_q : ymax_q;
                    end else begin
                        count_d = count_q;
                    end
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + CW'(1);
                    end else begin
                        x_d = x_q + CW'(1);
                    end
                    // The last pixel's own contribution is already folded into the _d values.
                    if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
                        if (count_d >= MIN_CNT) begin
                            state_d   = S_DIVIDE;
                            rem_x_d   = '0;
                            quo_x_d   = sum_x_d;
                            rem_y_d   = '0;
                            quo_y_d   = sum_y_d;
                            divisor_d = count_d;
                            step_d    = '0;
                        end else begin
                            state_d   = S_HOLD;
                            publish_s = 1'b1;
                        end
                    end else begin
                        state_d = S_ACCUM;
                    end
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_DIVIDE: begin
                overrun_d          = FRAME_START;
                {rem_x_d, quo_x_d} = step_x_s;
                {rem_y_d, quo_y_d} = step_y_s;
                step_d             = step_q + SCW'(1);
                if (step_q == LAST_STEP) begin
                    state_d     = S_HOLD;
                    publish_s   = 1'b1;
                    found_pub_s = 1'b1;
                end else begin
                    state_d = S_DIVIDE;
                end
            end
            S_HOLD: begin
                if (RESULT_ACK) begin
                    if (FRAME_START) begin
                        start_s = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    overrun_d = FRAME_START;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_s) begin
            state_d = S_ACCUM;
            x_d     = '0;
            y_d     = '0;
            sum_x_d = '0;
            sum_y_d = '0;
            count_d = '0;
            xmin_d  = '1;
            xmax_d  = '0;
            ymin_d  = '1;
            ymax_d  = '0;
            valid_d = 1'b0;
        end else if (publish_s) begin
            valid_d     = 1'b1;
            found_d     = found_pub_s;
            res_count_d = count_d;
            cent_x_d    = found_pub_s ? step_x_s[CW-1:0] : '0;
            cent_y_d    = found_pub_s ? step_y_s[CW-1:0] : '0;
            res_xmin_d  = xmin_d;
            res_xmax_d  = xmax_d;
            res_ymin_d  = ymin_d;
            res_ymax_d  = ymax_d;
        end else begin
            valid_d = valid_q & ~((state_q == S_HOLD) & RESULT_ACK);
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            sum_x_q     <= '0;
            sum_y_q     <= '0;
            count_q     <= '0;
            xmin_q      <= '1;
            xmax_q      <= '0;
            ymin_q      <= '1;
            ymax_q      <= '0;
            rem_x_q     <= '0;
            quo_x_q     <= '0;
            rem_y_q     <= '0;
            quo_y_q     <= '0;
            divisor_q   <= '0;
            step_q      <= '0;
            valid_q     <= 1'b0;
            found_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            res_count_q <= '0;
            cent_x_q    <= '0;
            cent_y_q    <= '0;
            res_xmin_q  <= '0;
            res_xmax_q  <= '0;
            res_ymin_q  <= '0;
            res_ymax_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sum_x_q     <= sum_x_d;
            sum_y_q     <= sum_y_d;
            count_q     <= count_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            rem_x_q     <= rem_x_d;
            quo_x_q     <= quo_x_d;
            rem_y_q     <= rem_y_d;
            quo_y_q     <= quo_y_d;
            divisor_q   <= divisor_d;
            step_q      <= step_d;
            valid_q     <= valid_d;
            found_q     <= found_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            res_count_q <= res_count_d;
            cent_x_q    <= cent_x_d;
            cent_y_q    <= cent_y_d;
            res_xmin_q  <= res_xmin_d;
            res_xmax_q  <= res_xmax_d;
            res_ymin_q  <= res_ymin_d;
            res_ymax_q  <= res_ymax_d;
        end
    end

    assign RESULT_VALID = valid_q;
    assign FOUND        = found_q;
    assign PIX_COUNT    = res_count_q;
    assign CENT_X       = cent_x_q;
    assign CENT_Y       = cent_y_q;
    assign XMIN         = res_xmin_q;
    assign XMAX         = res_xmax_q;
    assign YMIN         = res_ymin_q;
    assign YMAX         = res_ymax_q;
    assign BUSY         = busy_q;
    assign OVERRUN      = overrun_q;

endmodule

// File: tb/tb_binary_blob_tracker.sv
// Directed bench for binary_blob_tracker on a reduced 32x32 frame; expected values are
// hand-computed from the blob shapes drawn by pix_at().
module tb_binary_blob_tracker;

    localparam int H  = 32;
    localparam int V  = 32;
    localparam int CW = 11;

    logic          clk;
    logic          RESET, FRAME_START, PIX_VALID, BINARY_FLAG, RESULT_ACK;
    logic          RESULT_VALID, FOUND, BUSY, OVERRUN;
    logic [19:0]   PIX_COUNT;
    logic [CW-1:0] CENT_X, CENT_Y, XMIN, XMAX, YMIN, YMAX;

    int n_checks = 0;
    int n_errors = 0;

    binary_blob_tracker #(
        .H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(16), .CW(CW), .SUM_W(32)
    ) dut (
        .CLK(clk), .RESET(RESET), .FRAME_START(FRAME_START), .PIX_VALID(PIX_VALID),
        .BINARY_FLAG(BINARY_FLAG), .RESULT_VALID(RESULT_VALID), .RESULT_ACK(RESULT_ACK),
        .FOUND(FOUND), .PIX_COUNT(PIX_COUNT), .CENT_X(CENT_X), .CENT_Y(CENT_Y),
        .XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX), .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    // Free-running pixel clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Blob shapes: 1 = 3x3, 2 = 5x5, 3 = corner pixel plus 15 on the last row, else empty.
    function automatic logic pix_at(input int mode, input int x, input int y);
        case (mode)
            1:       return (x >= 10 && x <= 12 && y >= 5 && y <= 7);
            2:       return (x >= 10 && x <= 14 && y >= 20 && y <= 24);
            3:       return ((x == 0 && y == 0) || (y == V-1 && x >= 17));
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        FRAME_START = 1'b1;
        tick();
        FRAME_START = 1'b0;
    endtask

    task automatic send_pixels(input int mode, input int lines);
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < H; x++) begin
                PIX_VALID   = 1'b1;
                BINARY_FLAG = pix_at(mode, x, y);
                tick();
            end
        end
        PIX_VALID   = 1'b0;
        BINARY_FLAG = 1'b0;
    endtask

    // Latency counts edges from the one that samples the final pixel (that edge = 1).
    task automatic wait_result(output int lat);
        lat = 1;
        while (!RESULT_VALID && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic expect_result(input string t, input logic fnd, input int cnt, input int cx,
                                 input int cy, input int x0, input int x1, input int y0,
                                 input int y1, input int lat_exp, input int lat);
        check_eq({t, ".valid"}, RESULT_VALID, 1);
        check_eq({t, ".latency"}, lat, lat_exp);
        check_eq({t, ".found"}, FOUND, fnd);
        check_eq({t, ".count"}, PIX_COUNT, cnt);
        check_eq({t, ".cent_x"}, CENT_X, cx);
        check_eq({t, ".cent_y"}, CENT_Y, cy);
        check_eq({t, ".xmin"}, XMIN, x0);
        check_eq({t, ".xmax"}, XMAX, x1);
        check_eq({t, ".ymin"}, YMIN, y0);
        check_eq({t, ".ymax"}, YMAX, y1);
        check_eq({t, ".busy"}, BUSY, 1);
    endtask

    task automatic ack_result(input string t);
        RESULT_ACK = 1'b1;
        tick();
        RESULT_ACK = 1'b0;
        check_eq({t, ".ack_valid"}, RESULT_VALID, 0);
        check_eq({t, ".ack_busy"}, BUSY, 0);
    endtask

    initial begin
        int lat;
        int ov_cnt;
        int changed;
        logic [86:0] snap;

        RESET = 1'b1; FRAME_START = 1'b0; PIX_VALID = 1'b0; BINARY_FLAG = 1'b0;
        RESULT_ACK = 1'b0;
        repeat (3) tick();
        check_eq("rst.valid", RESULT_VALID, 0);
        check_eq("rst.busy", BUSY, 0);
        check_eq("rst.overrun", OVERRUN, 0);
        check_eq("rst.found", FOUND, 0);
        check_eq("rst.count", PIX_COUNT, 0);
        check_eq("rst.xmin", XMIN, 0);
        check_eq("rst.cent_x", CENT_X, 0);
        RESET = 1'b0;

        // Pixels while idle must not start or disturb anything.
        PIX_VALID = 1'b1; BINARY_FLAG = 1'b1;
        repeat (5) tick();
        PIX_VALID = 1'b0; BINARY_FLAG = 1'b0;
        check_eq("idle.busy", BUSY, 0);

        // Small blob below MIN_PIXELS.
        start_frame();
        check_eq("t1.busy_accum", BUSY, 1);
        send_pixels(1, V);
        wait_result(lat);
        expect_result("t1", 1'b0, 9, 0, 0, 10, 12, 5, 7, 1, lat);
        ack_result("t1");

        // Empty frame: bbox keeps its initial values.
        start_frame();
        send_pixels(0, V);
        wait_result(lat);
        expect_result("t0", 1'b0, 0, 0, 0, 2047, 0, 2047, 0, 1, lat);
        ack_result("t0");

        // 5x5 blob: 300/25, 550/25.
        start_frame();
        send_pixels(2, V);
        wait_result(lat);
        expect_result("t2", 1'b1, 25, 12, 22, 10, 14, 20, 24, 33, lat);
        ack_result("t2");

        // Extremes: sum_x = 360 -> 22, sum_y = 465 -> 29.
        start_frame();
        send_pixels(3, V);
        wait_result(lat);
        expect_result("t3", 1'b1, 16, 22, 29, 0, 31, 0, 31, 33, lat);
        ack_result("t3");

        // Long hold with a stray FRAME_START, then ACK+FRAME_START together.
        start_frame();
        send_pixels(1, V);
        wait_result(lat);
        expect_result("t4", 1'b0, 9, 0, 0, 10, 12, 5, 7, 1, lat);
        snap = {FOUND, PIX_COUNT, CENT_X, CENT_Y, XMIN, XMAX, YMIN, YMAX};
        ov_cnt = 0;
        changed = 0;
        for (int i = 0; i < 100; i++) begin
            FRAME_START = (i == 50);
            tick();
            if (OVERRUN) ov_cnt++;
            if (!RESULT_VALID || snap !== {FOUND, PIX_COUNT, CENT_X, CENT_Y, XMIN, XMAX, YMIN, YMAX})
                changed++;
        end
        FRAME_START = 1'b0;
        check_eq("t4.overrun_pulses", ov_cnt, 1);
        check_eq("t4.changes", changed, 0);
        RESULT_ACK = 1'b1; FRAME_START = 1'b1;
        tick();
        RESULT_ACK = 1'b0; FRAME_START = 1'b0;
        check_eq("t4.restart_valid", RESULT_VALID, 0);
        check_eq("t4.restart_busy", BUSY, 1);
        check_eq("t4.restart_overrun", OVERRUN, 0);
        send_pixels(2, V);
        wait_result(lat);
        expect_result("t4b", 1'b1, 25, 12, 22, 10, 14, 20, 24, 33, lat);
        ack_result("t4b");

        // Restart mid-frame; the partial frame's (0,0) pixel must not leak into the result.
        start_frame();
        send_pixels(3, 10);
        FRAME_START = 1'b1;
        tick();
        FRAME_START = 1'b0;
        check_eq("t5.overrun", OVERRUN, 1);
        check_eq("t5.busy", BUSY, 1);
        tick();
        check_eq("t5.overrun_end", OVERRUN, 0);
        send_pixels(1, V);
        wait_result(lat);
        expect_result("t5", 1'b0, 9, 0, 0, 10, 12, 5, 7, 1, lat);
        ack_result("t5");

        // Reset in the middle of the divide.
        start_frame();
        send_pixels(2, V);
        repeat (5) tick();
        check_eq("t6.dividing_busy", BUSY, 1);
        check_eq("t6.dividing_valid", RESULT_VALID, 0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_eq("t6.rst_valid", RESULT_VALID, 0);
        check_eq("t6.rst_busy", BUSY, 0);
        check_eq("t6.rst_count", PIX_COUNT, 0);
        check_eq("t6.rst_cent_x", CENT_X, 0);
        check_eq("t6.rst_xmax", XMAX, 0);
        repeat (40) tick();
        check_eq("t6.discarded", RESULT_VALID, 0);
        start_frame();
        send_pixels(3, V);
        wait_result(lat);
        expect_result("t6b", 1'b1, 16, 22, 29, 0, 31, 0, 31, 33, lat);
        ack_result("t6b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
